// File: rtl/gmii_tx_frame_checker.sv
// -----------------------------------------------------------------------------
// gmii_tx_frame_checker
//
// Byte-wide GMII transmit-path checker. It strips the preamble and SFD, runs a
// reflected CRC-32 over every byte after the SFD (FCS included), checks the
// frame length, forwards the payload with the FCS removed as a valid/last byte
// stream, and keeps saturating good/bad frame counters.
//
// Parameters
//   MIN_FRAME  minimum legal frame length, DA through FCS inclusive
//   MAX_FRAME  maximum legal frame length, inclusive
//   PRE_MIN    minimum number of 0x55 bytes required before the SFD
//   CNT_W      width of good_cnt / bad_cnt
//
// Ports
//   clk         in   1      GMII clock, all logic on the rising edge
//   reset_n     in   1      asynchronous active-low reset
//   gmii_txd    in   8      captured transmit byte
//   gmii_tx_en  in   1      frame-active qualifier
//   gmii_tx_er  in   1      error qualifier
//   m_tdata     out  8      payload byte (FCS excluded)
//   m_tvalid    out  1      m_tdata valid, no backpressure
//   m_tlast     out  1      last payload byte of the frame
//   frame_done  out  1      one-cycle pulse, status outputs valid this cycle
//   frame_good  out  1      no error flag set
//   frame_len   out  11     bytes after the SFD incl. FCS, saturates at 2047
//   crc_err     out  1      CRC residue mismatch
//   len_err     out  1      length outside [MIN_FRAME, MAX_FRAME]
//   er_err      out  1      gmii_tx_er seen inside the frame
//   pre_err     out  1      bad/short preamble or missing SFD
//   good_cnt    out  CNT_W  saturating good frame count
//   bad_cnt     out  CNT_W  saturating bad frame count
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------------
//   ST_IDLE  | between frames; unarmed after reset until tx_en is seen low
//   ST_PRE   | counting 0x55 preamble bytes, waiting for the SFD
//   ST_DATA  | frame body: CRC, length and payload pipeline active
//   ST_DROP  | preamble error, discard bytes until tx_en falls
// -----------------------------------------------------------------------------
module gmii_tx_frame_checker #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int PRE_MIN   = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       gmii_txd,
  input  logic             gmii_tx_en,
  input  logic             gmii_tx_er,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic             frame_done,
  output logic             frame_good,
  output logic [10:0]      frame_len,
  output logic             crc_err,
  output logic             len_err,
  output logic             er_err,
  output logic             pre_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PRE  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [7:0]       BYTE_PRE  = 8'h55;
  localparam logic [7:0]       BYTE_SFD  = 8'hD5;
  localparam logic [31:0]      CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_POLY  = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_RESID = 32'hDEBB_20E3;
  localparam logic [10:0]      LEN_SAT   = 11'h7FF;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // One byte of the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Frame-tracking state
  logic [1:0]       state_q,   state_d;
  logic             armed_q,   armed_d;
  logic [2:0]       pre_cnt_q, pre_cnt_d;
  logic [31:0]      crc_q,     crc_d;
  logic [10:0]      len_q,     len_d;
  logic             er_q,      er_d;
  logic [4:0][7:0]  sr_q,      sr_d;
  logic [2:0]       held_q,    held_d;

  // Registered outputs
  logic [7:0]       tdata_q,   tdata_d;
  logic             tvalid_q,  tvalid_d;
  logic             tlast_q,   tlast_d;
  logic             done_q,    done_d;
  logic             good_q,    good_d;
  logic [10:0]      flen_q,    flen_d;
  logic             crcerr_q,  crcerr_d;
  logic             lenerr_q,  lenerr_d;
  logic             ererr_q,   ererr_d;
  logic             preerr_q,  preerr_d;
  logic [CNT_W-1:0] gcnt_q,    gcnt_d;
  logic [CNT_W-1:0] bcnt_q,    bcnt_d;

  // Combinational close-of-frame helpers
  logic start_data;
  logic close_data;
  logic close_pre;
  logic pre_ok;
  logic crc_bad;
  logic len_bad;
  logic frame_ok;

  assign pre_ok  = ({29'd0, pre_cnt_q} >= 32'(PRE_MIN));
  assign crc_bad = (crc_q != CRC_RESID);
  assign len_bad = ({21'd0, len_q} < 32'(MIN_FRAME)) ||
                   ({21'd0, len_q} > 32'(MAX_FRAME));
  assign frame_ok = !crc_bad && !len_bad && !er_q;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    pre_cnt_d  = pre_cnt_q;
    crc_d      = crc_q;
    len_d      = len_q;
    er_d       = er_q;
    sr_d       = sr_q;
    held_d     = held_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    done_d     = 1'b0;
    good_d     = good_q;
    flen_d     = flen_q;
    crcerr_d   = crcerr_q;
    lenerr_d   = lenerr_q;
    ererr_d    = ererr_q;
    preerr_d   = preerr_q;
    gcnt_d     = gcnt_q;
    bcnt_d     = bcnt_q;
    start_data = 1'b0;
    close_data = 1'b0;
    close_pre  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Coming out of reset we may be in the middle of a frame; stay
        // silent until the line has been seen idle once.
        if (!armed_q) begin
          if (!gmii_tx_en) armed_d = 1'b1;
        end else if (gmii_tx_en) begin
          if (gmii_txd == BYTE_PRE) begin
            state_d   = ST_PRE;
            pre_cnt_d = 3'd1;
          end else if ((PRE_MIN == 0) && (gmii_txd == BYTE_SFD)) begin
            start_data = 1'b1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PRE: begin
        // tx_en falling here behaves like DROP seeing the line already idle.
        if (!gmii_tx_en) begin
          close_pre = 1'b1;
        end else if (gmii_txd == BYTE_PRE) begin
          if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
        end else if ((gmii_txd == BYTE_SFD) && pre_ok) begin
          start_data = 1'b1;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (gmii_tx_en) begin
          crc_d = crc32_byte(crc_q, gmii_txd);
          if (len_q != LEN_SAT) len_d = len_q + 11'd1;
          if (gmii_tx_er) er_d = 1'b1;
          sr_d = {sr_q[3:0], gmii_txd};
          // Once the pipe is full, every new byte pushes the oldest one out.
          if (held_q == 3'd5) begin
            tvalid_d = 1'b1;
            tdata_d  = sr_q[4];
          end else begin
            held_d = held_q + 3'd1;
          end
        end else begin
          close_data = 1'b1;
        end
      end

      ST_DROP: begin
        if (!gmii_tx_en) close_pre = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase

    if (start_data) begin
      state_d = ST_DATA;
      crc_d   = CRC_INIT;
      len_d   = '0;
      er_d    = 1'b0;
      held_d  = '0;
    end

    if (close_data) begin
      state_d  = ST_IDLE;
      done_d   = 1'b1;
      good_d   = frame_ok;
      flen_d   = len_q;
      crcerr_d = crc_bad;
      lenerr_d = len_bad;
      ererr_d  = er_q;
      preerr_d = 1'b0;
      // With a full pipe the oldest held byte is the last payload byte;
      // the four younger ones are the FCS and are dropped.
      if (held_q == 3'd5) begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        tdata_d  = sr_q[4];
      end
      if (frame_ok) begin
        if (gcnt_q != '1) gcnt_d = gcnt_q + CNT_ONE;
      end else begin
        if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_ONE;
      end
    end

    if (close_pre) begin
      state_d  = ST_IDLE;
      done_d   = 1'b1;
      good_d   = 1'b0;
      flen_d   = '0;
      crcerr_d = 1'b0;
      lenerr_d = 1'b0;
      ererr_d  = 1'b0;
      preerr_d = 1'b1;
      if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      pre_cnt_q <= '0;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      er_q      <= 1'b0;
      sr_q      <= '0;
      held_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      done_q    <= 1'b0;
      good_q    <= 1'b0;
      flen_q    <= '0;
      crcerr_q  <= 1'b0;
      lenerr_q  <= 1'b0;
      ererr_q   <= 1'b0;
      preerr_q  <= 1'b0;
      gcnt_q    <= '0;
      bcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      pre_cnt_q <= pre_cnt_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      er_q      <= er_d;
      sr_q      <= sr_d;
      held_q    <= held_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      done_q    <= done_d;
      good_q    <= good_d;
      flen_q    <= flen_d;
      crcerr_q  <= crcerr_d;
      lenerr_q  <= lenerr_d;
      ererr_q   <= ererr_d;
      preerr_q  <= preerr_d;
      gcnt_q    <= gcnt_d;
      bcnt_q    <= bcnt_d;
    end
  end

  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign m_tlast    = tlast_q;
  assign frame_done = done_q;
  assign frame_good = good_q;
  assign frame_len  = flen_q;
  assign crc_err    = crcerr_q;
  assign len_err    = lenerr_q;
  assign er_err     = ererr_q;
  assign pre_err    = preerr_q;
  assign good_cnt   = gcnt_q;
  assign bad_cnt    = bcnt_q;

endmodule

// File: tb/tb_gmii_tx_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_gmii_tx_frame_checker
//
// Drives directed and randomized GMII frames into two checker instances
// (default counter width and CNT_W=4). Expected results come from a frame-level
// reference model: preamble parsed by rule, FCS recomputed over the payload and
// compared byte-for-byte, payload beats and counters derived from the frame.
// -----------------------------------------------------------------------------
module tb_gmii_tx_frame_checker;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;
  localparam int PRE_MIN   = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        gmii_tx_er;

  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, frame_done, frame_good;
  logic [10:0] frame_len;
  logic        crc_err, len_err, er_err, pre_err;
  logic [31:0] good_cnt, bad_cnt;

  logic [7:0]  m_tdata_4;
  logic        m_tvalid_4, m_tlast_4, frame_done_4, frame_good_4;
  logic [10:0] frame_len_4;
  logic        crc_err_4, len_err_4, er_err_4, pre_err_4;
  logic [3:0]  good_cnt_4, bad_cnt_4;

  always #4 clk = ~clk;

  gmii_tx_frame_checker #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME),
                          .PRE_MIN(PRE_MIN), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .gmii_txd(gmii_txd),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .frame_done(frame_done), .frame_good(frame_good), .frame_len(frame_len),
    .crc_err(crc_err), .len_err(len_err), .er_err(er_err), .pre_err(pre_err),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt));

  gmii_tx_frame_checker #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME),
                          .PRE_MIN(PRE_MIN), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .gmii_txd(gmii_txd),
    .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
    .m_tdata(m_tdata_4), .m_tvalid(m_tvalid_4), .m_tlast(m_tlast_4),
    .frame_done(frame_done_4), .frame_good(frame_good_4), .frame_len(frame_len_4),
    .crc_err(crc_err_4), .len_err(len_err_4), .er_err(er_err_4), .pre_err(pre_err_4),
    .good_cnt(good_cnt_4), .bad_cnt(bad_cnt_4));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit good;
    int len;
    bit crc_e;
    bit len_e;
    bit er_e;
    bit pre_e;
    int nbeats;
    int gcnt;
    int bcnt;
  } exp_t;

  logic [7:0] tx_b[$];
  bit         tx_e[$];
  exp_t       exp_q[$];
  logic [8:0] exp_beats[$];
  int         m_good = 0;
  int         m_bad  = 0;
  int         cyc    = 0;
  int         fall_cyc = 0;
  bit         ignore_out = 1'b0;
  int         beats_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Ethernet FCS over tx_b[start +: n]: reflected CRC-32 with final inversion.
  function automatic logic [31:0] ref_fcs(input int start, input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, tx_b[start + i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // npre x 0x55, sfd, plen payload bytes, 4-byte FCS (optionally one bit flipped).
  task automatic make_frame(input int npre, input logic [7:0] sfd, input int plen,
                            input bit zero, input int flip);
    logic [31:0] fcs;
    int          s;
    tx_b.delete();
    tx_e.delete();
    for (int i = 0; i < npre; i++) tx_b.push_back(8'h55);
    tx_b.push_back(sfd);
    s = tx_b.size();
    for (int i = 0; i < plen; i++) tx_b.push_back(zero ? 8'h00 : 8'($urandom));
    fcs = ref_fcs(s, plen);
    if (flip >= 0) fcs[flip] = ~fcs[flip];
    for (int i = 0; i < 4; i++) tx_b.push_back(fcs[8*i +: 8]);
    for (int i = 0; i < tx_b.size(); i++) tx_e.push_back(1'b0);
  endtask

  task automatic expect_frame();
    exp_t e;
    int   k, n, s, dn;
    e = '{default: 0};
    n = tx_b.size();
    k = 0;
    while (k < n && tx_b[k] == 8'h55) k++;
    if (k == n || tx_b[k] != 8'hD5 || k < PRE_MIN) e.pre_e = 1'b1;
    if (!e.pre_e) begin
      s  = k + 1;
      dn = n - s;
      e.len   = (dn > 2047) ? 2047 : dn;
      e.len_e = (dn < MIN_FRAME) || (dn > MAX_FRAME);
      if (dn >= 4)
        e.crc_e = (ref_fcs(s, dn - 4) != {tx_b[n-1], tx_b[n-2], tx_b[n-3], tx_b[n-4]});
      else
        e.crc_e = 1'b1;
      for (int i = s; i < n; i++) if (tx_e[i]) e.er_e = 1'b1;
      if (dn >= 5) begin
        e.nbeats = dn - 4;
        for (int i = 0; i < dn - 4; i++) exp_beats.push_back({(i == dn - 5), tx_b[s + i]});
      end
    end
    e.good = !(e.pre_e || e.len_e || e.crc_e || e.er_e);
    if (e.good) m_good++; else m_bad++;
    e.gcnt = m_good;
    e.bcnt = m_bad;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- driver
  task automatic drive(input logic en, input logic [7:0] d, input logic er);
    @(posedge clk);
    #1;
    gmii_tx_en = en;
    gmii_txd   = d;
    gmii_tx_er = er;
  endtask

  task automatic send(input int gap);
    for (int i = 0; i < tx_b.size(); i++) drive(1'b1, tx_b[i], tx_e[i]);
    drive(1'b0, 8'($urandom), 1'b0);
    fall_cyc = cyc;
    for (int i = 1; i < gap; i++) drive(1'b0, 8'($urandom), 1'b0);
  endtask

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    exp_t       e;
    logic [8:0] b;
    forever begin
      @(negedge clk);
      if (ignore_out) begin
        chk("abort_no_done", {31'd0, frame_done}, 0);
      end else begin
        if (m_tvalid) begin
          chk("beat_expected", {63'd0, exp_beats.size() != 0}, 1);
          if (exp_beats.size() != 0) begin
            b = exp_beats.pop_front();
            chk("beat_data", m_tdata, b[7:0]);
            chk("beat_last", m_tlast, b[8]);
            chk("beat4_data", {m_tvalid_4, m_tdata_4}, {1'b1, b[7:0]});
          end
          beats_seen++;
        end else begin
          chk("tlast_idle", m_tlast, 0);
        end
        if (frame_done) begin
          chk("done_expected", {63'd0, exp_q.size() != 0}, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("done_latency", cyc - fall_cyc, 1);
            chk("frame_good", frame_good, e.good);
            chk("frame_len", frame_len, e.len);
            chk("crc_err", crc_err, e.crc_e);
            chk("len_err", len_err, e.len_e);
            chk("er_err", er_err, e.er_e);
            chk("pre_err", pre_err, e.pre_e);
            chk("n_beats", beats_seen, e.nbeats);
            chk("good_cnt", good_cnt, e.gcnt);
            chk("bad_cnt", bad_cnt, e.bcnt);
            chk("done4", {frame_done_4, frame_good_4, frame_len_4},
                {1'b1, e.good, 11'(e.len)});
            chk("flags4", {crc_err_4, len_err_4, er_err_4, pre_err_4},
                {e.crc_e, e.len_e, e.er_e, e.pre_e});
            chk("good_cnt4", good_cnt_4, (e.gcnt > 15) ? 15 : e.gcnt);
            chk("bad_cnt4", bad_cnt_4, (e.bcnt > 15) ? 15 : e.bcnt);
          end
          beats_seen = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  int         kind, npre, plen, flip;
  logic [7:0] sfd;

  initial begin : stim
    reset_n    = 1'b0;
    gmii_tx_en = 1'b0;
    gmii_tx_er = 1'b0;
    gmii_txd   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stream", {m_tvalid, m_tlast, m_tdata}, 0);
    chk("rst_status", {frame_done, frame_good, frame_len, crc_err, len_err, er_err, pre_err}, 0);
    chk("rst_cnt", {good_cnt, bad_cnt}, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    // Reference good frame, then the same with a corrupted FCS bit.
    make_frame(7, 8'hD5, 60, 1, -1); expect_frame(); send(6);
    make_frame(7, 8'hD5, 60, 1, 0);  expect_frame(); send(6);
    // Runt with valid FCS.
    make_frame(7, 8'hD5, 36, 0, -1); expect_frame(); send(6);
    // tx_er mid-payload, then a clean frame.
    make_frame(7, 8'hD5, 60, 0, -1); tx_e[8 + 30] = 1'b1; expect_frame(); send(6);
    make_frame(7, 8'hD5, 60, 0, -1); expect_frame(); send(6);
    // Bad SFD.
    make_frame(7, 8'h57, 60, 1, -1); expect_frame(); send(6);

    // Reset in the middle of a frame, line still active when reset releases.
    ignore_out = 1'b1;
    make_frame(7, 8'hD5, 60, 0, -1);
    for (int i = 0; i < 30; i++) drive(1'b1, tx_b[i], 1'b0);
    reset_n = 1'b0;
    for (int i = 30; i < 40; i++) begin
      drive(1'b1, tx_b[i], 1'b0);
      if (i == 33) reset_n = 1'b1;
    end
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    ignore_out = 1'b0;
    beats_seen = 0;
    m_good = 0;
    m_bad  = 0;
    chk("rst_mid_cnt", {good_cnt, bad_cnt}, 0);
    make_frame(7, 8'hD5, 60, 0, -1); expect_frame(); send(4);

    // Length and preamble boundaries.
    make_frame(7, 8'hD5, 59, 0, -1);   expect_frame(); send(3);
    make_frame(1, 8'hD5, 60, 0, -1);   expect_frame(); send(3);
    make_frame(12, 8'hD5, 1514, 0, -1); expect_frame(); send(3);
    make_frame(7, 8'hD5, 1515, 0, -1); expect_frame(); send(3);
    make_frame(7, 8'hD5, 2056, 0, -1); expect_frame(); send(3);
    make_frame(0, 8'hD5, 60, 0, -1);   expect_frame(); send(3);
    tx_b.delete(); tx_e.delete();
    for (int i = 0; i < 3; i++) begin tx_b.push_back(8'h55); tx_e.push_back(1'b0); end
    expect_frame(); send(3);
    tx_b.delete(); tx_e.delete();
    for (int i = 0; i < 7; i++) begin tx_b.push_back(8'h55); tx_e.push_back(1'b0); end
    tx_b.push_back(8'hD5); tx_b.push_back(8'h12); tx_b.push_back(8'h34);
    for (int i = 0; i < 3; i++) tx_e.push_back(1'b0);
    expect_frame(); send(3);

    // Back-to-back good frames drive the 4-bit counter into saturation.
    for (int f = 0; f < 17; f++) begin
      make_frame(7, 8'hD5, 60, 0, -1); expect_frame(); send(1);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("good_cnt4_sat", good_cnt_4, 15);
    chk("good_cnt_wide", good_cnt, m_good);

    // Randomized mix.
    for (int f = 0; f < 60; f++) begin
      kind = $urandom_range(0, 7);
      npre = $urandom_range(1, 10);
      plen = $urandom_range(46, 140);
      sfd  = 8'hD5;
      flip = -1;
      case (kind)
        4: flip = $urandom_range(0, 31);
        6: begin
          sfd = 8'($urandom);
          if (sfd == 8'hD5) sfd = 8'h57;
        end
        7: plen = $urandom_range(4, 59);
        default: ;
      endcase
      make_frame(npre, sfd, plen, 1'b0, flip);
      if (kind == 5) tx_e[npre + 1 + $urandom_range(0, plen - 1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) tx_e[$urandom_range(0, npre - 1)] = 1'b1;
      expect_frame();
      send($urandom_range(1, 5));
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("pending_frames", exp_q.size(), 0);
    chk("pending_beats", exp_beats.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
